rf_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback requesters: A (ALU result) and B (load data). It arbitrates round-robin and registers the winning write into the register file's write port, one cycle after acceptance. It also keeps a 32-entry pending-write scoreboard so the decode stage can detect read-after-write hazards on its two read addresses. It sits between the execute/memory writeback paths and the register file.

---
 rtl/rf_wb_arbiter.sv | 106 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B)
// writebacks, with a pending-write scoreboard that flags read-after-write hazards for decode.
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_valid,
    input  logic [ADDR_W-1:0]      alloc_rd,
    input  logic                   a_valid,
    input  logic [ADDR_W-1:0]      a_rd,
    input  logic [DATA_W-1:0]      a_data,
    output logic                   a_ready,
    input  logic                   b_valid,
    input  logic [ADDR_W-1:0]      b_rd,
    input  logic [DATA_W-1:0]      b_data,
    output logic                   b_ready,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_wr,
    output logic [DATA_W-1:0]      rf_wd,
    input  logic [ADDR_W-1:0]      rr1,
    input  logic [ADDR_W-1:0]      rr2,
    output logic                   hazard,
    output logic [2**ADDR_W-1:0]   pending,
    output logic                   alloc_err
);

    localparam int NREG = 2**ADDR_W;

    // Handshake: a write transfers on a posedge where valid && ready; a requester that sees
    // ready=0 holds valid, rd and data stable. Nothing is accepted while rst is asserted.
    logic                last_b;
    logic                grant_a;
    logic                grant_b;
    logic [ADDR_W-1:0]   win_rd;
    logic [DATA_W-1:0]   win_data;
    logic [NREG-1:0]     set_vec;
    logic [NREG-1:0]     clr_vec;
    logic [NREG-1:0]     pending_next;
    logic                alloc_conflict;

    always_comb begin
        grant_a  = !rst && a_valid && (!b_valid || last_b);
        grant_b  = !rst && b_valid && !grant_a;
        win_rd   = grant_a ? a_rd : b_rd;
        win_data = grant_a ? a_data : b_data;
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b <= 1'b1;
        end else if (grant_a) begin
            last_b <= 1'b0;
        end else if (grant_b) begin
            last_b <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_wr <= '0;
            rf_wd <= '0;
        end else if (grant_a || grant_b) begin
            rf_we <= (win_rd != '0);
            rf_wr <= win_rd;
            rf_wd <= win_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    // A new claim beats a same-edge retirement: the new producer owns the register.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (alloc_valid) begin
            set_vec[alloc_rd] = 1'b1;
        end
        if (rf_we) begin
            clr_vec[rf_wr] = 1'b1;
        end
        pending_next    = set_vec | (pending & ~clr_vec);
        pending_next[0] = 1'b0;
        alloc_conflict  = alloc_valid && (alloc_rd != '0) && pending[alloc_rd] && !clr_vec[alloc_rd];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            alloc_err <= 1'b0;
        end else begin
            pending <= pending_next;
            if (alloc_conflict) begin
                alloc_err <= 1'b1;
            end
        end
    end

    assign hazard = pending[rr1] | pending[rr2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed scenarios plus randomized traffic checked
// against a rule-level model of grants, the output register and the pending set.
module tb_rf_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;
    localparam int QW     = 1 + ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              alloc_valid = 1'b0;
    logic [ADDR_W-1:0] alloc_rd = '0;
    logic              a_valid = 1'b0;
    logic [ADDR_W-1:0] a_rd = '0;
    logic [DATA_W-1:0] a_data = '0;
    logic              a_ready;
    logic              b_valid = 1'b0;
    logic [ADDR_W-1:0] b_rd = '0;
    logic [DATA_W-1:0] b_data = '0;
    logic              b_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wr;
    logic [DATA_W-1:0] rf_wd;
    logic [ADDR_W-1:0] rr1 = '0;
    logic [ADDR_W-1:0] rr2 = '0;
    logic              hazard;
    logic [NREG-1:0]   pending;
    logic              alloc_err;

    rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd),
        .rr1(rr1), .rr2(rr2), .hazard(hazard), .pending(pending), .alloc_err(alloc_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [QW-1:0] exp_q[$];

    // reference model state
    logic              m_last_b;
    logic [NREG-1:0]   m_pend;
    logic              m_err;
    logic              m_we;
    logic [ADDR_W-1:0] m_wr;
    logic [DATA_W-1:0] m_wd;
    logic              m_ga;
    logic              m_gb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last_b = 1'b1;
        m_pend   = '0;
        m_err    = 1'b0;
        m_we     = 1'b0;
        m_wr     = '0;
        m_wd     = '0;
        m_ga     = 1'b0;
        m_gb     = 1'b0;
        exp_q.delete();
    endtask

    // Applies the clock-edge rules to the model and queues the expected output register.
    task automatic model_edge();
        logic [NREG-1:0] np;
        logic set, clr;
        np = m_pend;
        for (int r = 1; r < NREG; r++) begin
            set = alloc_valid && (alloc_rd == r);
            clr = m_we && (m_wr == r);
            if (set && m_pend[r] && !clr) m_err = 1'b1;
            np[r] = set || (m_pend[r] && !clr);
        end
        m_pend = np;
        if (m_ga) begin
            m_we = (a_rd != 0); m_wr = a_rd; m_wd = a_data; m_last_b = 1'b0;
        end else if (m_gb) begin
            m_we = (b_rd != 0); m_wr = b_rd; m_wd = b_data; m_last_b = 1'b1;
        end else begin
            m_we = 1'b0;
        end
        exp_q.push_back({m_we, m_wr, m_wd});
    endtask

    // One clock: check combinational outputs mid-cycle, step the model at the edge.
    task automatic cycle();
        @(negedge clk);
        m_ga = a_valid && (!b_valid || m_last_b);
        m_gb = b_valid && !m_ga;
        chk("a_ready", a_ready, m_ga);
        chk("b_ready", b_ready, m_gb);
        chk("hazard", hazard, m_pend[rr1] | m_pend[rr2]);
        chk("pending", pending, m_pend);
        chk("alloc_err", alloc_err, m_err);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // monitor: every mid-cycle, compare the output register against the oldest expectation
    initial begin
        logic [QW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_we", rf_we, e[QW-1]);
                chk("rf_wr", rf_wr, e[DATA_W +: ADDR_W]);
                chk("rf_wd", rf_wd, e[DATA_W-1:0]);
            end
        end
    end

    // driver tasks
    task automatic drive(input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                         input logic bv, input logic [ADDR_W-1:0] brd, input logic [DATA_W-1:0] bd,
                         input logic alv, input logic [ADDR_W-1:0] alrd,
                         input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        alloc_valid = alv; alloc_rd = alrd;
        rr1 = r1; rr2 = r2;
        cycle();
    endtask

    task automatic idle(input logic [ADDR_W-1:0] r1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
    endtask

    function automatic logic [ADDR_W-1:0] pick_rd();
        int off;
        if ($urandom_range(0, 2) != 0) begin
            off = int'($urandom_range(0, NREG - 1));
            for (int k = 0; k < NREG; k++) begin
                if (m_pend[(off + k) % NREG]) return ADDR_W'((off + k) % NREG);
            end
        end
        return ADDR_W'($urandom_range(0, NREG - 1));
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rf_we"}, rf_we, 0);
        chk({tag, "_rf_wr"}, rf_wr, 0);
        chk({tag, "_rf_wd"}, rf_wd, 0);
        chk({tag, "_pending"}, pending, 0);
        chk({tag, "_alloc_err"}, alloc_err, 0);
    endtask

    task automatic apply_reset();
        #1;
        rst = 1'b1;
        a_valid = 0; b_valid = 0; alloc_valid = 0;
        #1;
        check_reset_outputs("rst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] rd;
        logic alv;
        model_reset();

        // reset held with random inputs
        repeat (3) begin
            @(posedge clk);
            #1;
            a_valid = 1'($urandom); a_rd = ADDR_W'($urandom); a_data = $urandom;
            b_valid = 1'($urandom); b_rd = ADDR_W'($urandom); b_data = $urandom;
            alloc_valid = 1'($urandom); alloc_rd = ADDR_W'($urandom);
            rr1 = ADDR_W'($urandom); rr2 = ADDR_W'($urandom);
            @(negedge clk);
            check_reset_outputs("hold_rst");
            chk("hold_rst_a_ready", a_ready, 0);
            chk("hold_rst_b_ready", b_ready, 0);
            chk("hold_rst_hazard", hazard, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // first tie after reset goes to A, then B
        d = $urandom;
        drive(1, 3, $urandom, 1, 4, d, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 4, d, 0, 0, 0, 0);
        idle(0);

        // sustained contention, fresh rd for each winner
        a_valid = 1; a_rd = ADDR_W'($urandom_range(10, 20)); a_data = $urandom;
        b_valid = 1; b_rd = ADDR_W'($urandom_range(21, 31)); b_data = $urandom;
        repeat (6) begin
            cycle();
            if (m_ga) begin a_rd = ADDR_W'($urandom_range(10, 20)); a_data = $urandom; end
            else      begin b_rd = ADDR_W'($urandom_range(21, 31)); b_data = $urandom; end
        end
        idle(0);

        // scoreboard set, writeback, hazard drop two cycles after handshake
        drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        idle(7);
        drive(1, 7, $urandom, 0, 0, 0, 0, 0, 7, 0);
        idle(7);
        idle(7);
        idle(7);

        // same-edge set and clear of r9
        drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        drive(1, 9, $urandom, 0, 0, 0, 0, 0, 9, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        idle(9);
        chk("same_edge_pend9", pending[9], 1);
        chk("same_edge_err", alloc_err, 0);

        // x0: accepted but not written; alloc to x0 ignored
        drive(0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(0);
        chk("x0_pend0", pending[0], 0);

        // double alloc of r5 sets sticky alloc_err
        drive(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 5, 5, 0);
        idle(5);
        drive(1, 5, $urandom, 0, 0, 0, 0, 0, 5, 0);
        idle(5);
        idle(5);
        chk("alloc_err_sticky", alloc_err, 1);
        apply_reset();
        idle(0);

        // randomized traffic with one mid-operation reset
        a_valid = 0; b_valid = 0;
        for (int i = 0; i < 500; i++) begin
            if (i == 250) begin
                drive(1, 17, $urandom, 0, 0, 0, 0, 0, 0, 0);
                chk("pre_reset_we", rf_we, 1);
                apply_reset();
                a_valid = 0; b_valid = 0;
            end
            if (!a_valid || m_ga) begin
                a_valid = ($urandom_range(0, 2) != 0); a_rd = pick_rd(); a_data = $urandom;
            end
            if (!b_valid || m_gb) begin
                b_valid = ($urandom_range(0, 2) != 0); b_rd = pick_rd(); b_data = $urandom;
            end
            rd  = ADDR_W'($urandom_range(0, NREG - 1));
            alv = ($urandom_range(0, 2) == 0) && !m_pend[rd];
            alloc_valid = alv; alloc_rd = rd;
            rr1 = pick_rd(); rr2 = pick_rd();
            cycle();
            // a granted transaction must not be re-presented unless freshly chosen
        end
        idle(0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
